// File: rtl/boot_sequencer_pkg.sv
// Shared encodings for the boot sequencer: FSM state codes, header field positions
// and the counter width used by the write-port address generators.
package boot_sequencer_pkg;

   localparam int unsigned BOOT_CNT_W = 16;

   // Header word layout: instruction count in the upper half, data count in the lower.
   localparam int unsigned BOOT_HDR_ICNT_MSB = 31;
   localparam int unsigned BOOT_HDR_ICNT_LSB = 16;
   localparam int unsigned BOOT_HDR_DCNT_MSB = 15;
   localparam int unsigned BOOT_HDR_DCNT_LSB = 0;

   localparam logic [2:0] BOOT_IDLE   = 3'd0;
   localparam logic [2:0] BOOT_HDR    = 3'd1;
   localparam logic [2:0] BOOT_LOAD_D = 3'd2;
   localparam logic [2:0] BOOT_LOAD_I = 3'd3;
   localparam logic [2:0] BOOT_CHK    = 3'd4;
   localparam logic [2:0] BOOT_RUN    = 3'd5;
   localparam logic [2:0] BOOT_DONE   = 3'd6;
   localparam logic [2:0] BOOT_ERR    = 3'd7;

   // States in which the sequencer consumes stream words (and counts as busy).
   function automatic logic boot_takes_stream(input logic [2:0] st);
      return (st == BOOT_HDR) || (st == BOOT_LOAD_D) || (st == BOOT_LOAD_I) || (st == BOOT_CHK);
   endfunction

endpackage

// File: rtl/boot_sequencer_wr_port.sv
// Registered BRAM write-port generator: one word in, one single-cycle write pulse out
// on the next cycle at byte address word_index*4.
module boot_wr_port
   import boot_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_dat,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_dat,
   output logic              o_enb
);

   logic [BOOT_CNT_W-1:0] r_cnt;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_dat;
   logic                  r_enb;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_addr <= '0;
         r_dat  <= '0;
         r_enb  <= 1'b0;
      end else begin
         r_enb <= i_wr;
         if (i_clr) begin
            r_cnt <= '0;
         end else if (i_wr) begin
            r_cnt  <= r_cnt + 1'b1;
            // Counts are bounded by the MAX params, so the truncation never bites.
            r_addr <= ADDR_W'({r_cnt, 2'b00});
            r_dat  <= i_dat;
         end
      end
   end

   assign o_addr = r_addr;
   assign o_dat  = r_dat;
   assign o_enb  = r_enb;

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: loads a header-described image from a word stream into data then
// instruction BRAM, then releases the CPU. Optional trailing checksum: BOOT_CHECKSUM_EN.
module boot_sequencer
   import boot_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned D_WORDS_MAX = 256,
   parameter int unsigned I_WORDS_MAX = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic [ADDR_W-1:0] d_w_addr,
   output logic [DATA_W-1:0] d_w_dat,
   output logic              d_w_enb,
   output logic [ADDR_W-1:0] i_w_addr,
   output logic [DATA_W-1:0] i_w_dat,
   output logic              i_w_enb,
   output logic              d_bram_init_done,
   output logic              pc_stall,
   output logic              i_r_enb,
   output logic              rd_enbl,
   output logic              busy,
   output logic              error
);

   localparam logic [BOOT_CNT_W:0] LP_D_MAX = 17'(D_WORDS_MAX);
   localparam logic [BOOT_CNT_W:0] LP_I_MAX = 17'(I_WORDS_MAX);
`ifdef BOOT_CHECKSUM_EN
   localparam logic [2:0] LP_END_ST = BOOT_CHK;
`else
   localparam logic [2:0] LP_END_ST = BOOT_RUN;
`endif

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [BOOT_CNT_W-1:0] r_left;
   logic [BOOT_CNT_W-1:0] w_left_nxt;
   logic [BOOT_CNT_W-1:0] r_i_cnt;
   logic [BOOT_CNT_W-1:0] w_i_cnt_nxt;
   logic [BOOT_CNT_W-1:0] w_hdr_d;
   logic [BOOT_CNT_W-1:0] w_hdr_i;
   logic                  w_acc;
   logic                  w_d_wr;
   logic                  w_i_wr;
   logic                  w_hdr_clr;
`ifdef BOOT_CHECKSUM_EN
   logic [DATA_W-1:0]     r_xor;
`endif

   assign w_acc     = s_valid & s_ready;
   assign w_hdr_d   = s_data[BOOT_HDR_DCNT_MSB:BOOT_HDR_DCNT_LSB];
   assign w_hdr_i   = s_data[BOOT_HDR_ICNT_MSB:BOOT_HDR_ICNT_LSB];
   assign w_hdr_clr = (r_state == BOOT_HDR);

   always_comb begin
      w_state_nxt = r_state;
      w_left_nxt  = r_left;
      w_i_cnt_nxt = r_i_cnt;
      w_d_wr      = 1'b0;
      w_i_wr      = 1'b0;
      case (r_state)
         BOOT_IDLE, BOOT_DONE: begin
            if (start) begin
               w_state_nxt = BOOT_HDR;
            end
         end
         BOOT_HDR: begin
            if (w_acc) begin
               w_i_cnt_nxt = w_hdr_i;
               if (({1'b0, w_hdr_d} > LP_D_MAX) || ({1'b0, w_hdr_i} > LP_I_MAX)) begin
                  w_state_nxt = BOOT_ERR;
               end else if (w_hdr_d != '0) begin
                  w_left_nxt  = w_hdr_d;
                  w_state_nxt = BOOT_LOAD_D;
               end else if (w_hdr_i != '0) begin
                  w_left_nxt  = w_hdr_i;
                  w_state_nxt = BOOT_LOAD_I;
               end else begin
                  w_state_nxt = LP_END_ST;
               end
            end
         end
         BOOT_LOAD_D: begin
            if (w_acc) begin
               w_d_wr = 1'b1;
               if (r_left == 16'd1) begin
                  if (r_i_cnt != '0) begin
                     w_left_nxt  = r_i_cnt;
                     w_state_nxt = BOOT_LOAD_I;
                  end else begin
                     w_state_nxt = LP_END_ST;
                  end
               end else begin
                  w_left_nxt = r_left - 1'b1;
               end
            end
         end
         BOOT_LOAD_I: begin
            if (w_acc) begin
               w_i_wr = 1'b1;
               if (r_left == 16'd1) begin
                  w_state_nxt = LP_END_ST;
               end else begin
                  w_left_nxt = r_left - 1'b1;
               end
            end
         end
`ifdef BOOT_CHECKSUM_EN
         BOOT_CHK: begin
            if (w_acc) begin
               w_state_nxt = (s_data == r_xor) ? BOOT_RUN : BOOT_ERR;
            end
         end
`endif
         BOOT_RUN: w_state_nxt = BOOT_DONE;
         BOOT_ERR: w_state_nxt = BOOT_ERR;
         default:  w_state_nxt = BOOT_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= BOOT_IDLE;
         r_left  <= '0;
         r_i_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_left  <= w_left_nxt;
         r_i_cnt <= w_i_cnt_nxt;
      end
   end

`ifdef BOOT_CHECKSUM_EN
   // Running XOR restarts with the header word itself.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_xor <= '0;
      end else if (w_hdr_clr && w_acc) begin
         r_xor <= s_data;
      end else if (w_d_wr || w_i_wr) begin
         r_xor <= r_xor ^ s_data;
      end
   end
`endif

   boot_wr_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_d_port (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_hdr_clr),
      .i_wr   (w_d_wr),
      .i_dat  (s_data),
      .o_addr (d_w_addr),
      .o_dat  (d_w_dat),
      .o_enb  (d_w_enb)
   );

   boot_wr_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_i_port (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_hdr_clr),
      .i_wr   (w_i_wr),
      .i_dat  (s_data),
      .o_addr (i_w_addr),
      .o_dat  (i_w_dat),
      .o_enb  (i_w_enb)
   );

   // All control outputs decode the state register; the CPU sees init_done one
   // cycle (RUN) before the PC is released in DONE.
   assign s_ready          = boot_takes_stream(r_state);
   assign busy             = boot_takes_stream(r_state);
   assign d_bram_init_done = (r_state == BOOT_RUN) || (r_state == BOOT_DONE);
   assign pc_stall         = (r_state != BOOT_DONE);
   assign i_r_enb          = (r_state == BOOT_DONE);
   assign rd_enbl          = (r_state == BOOT_DONE);
   assign error            = (r_state == BOOT_ERR);

endmodule
